pipe_ctrl_unit: RTL and testbench

Hazard and sequencing controller for the 5-stage pipelined datapath. Produces PC-write and PC-source select for the 4:1 PC input mux, IF/ID write-enable and flush, and ID/EX bubble insertion. Detects load-use hazards, squashes wrong-path instructions on EX-resolved redirects (branch/jump/call/return), and tracks call-stack depth. Sequences an orderly drain-and-halt when the halt instruction is fetched.

---
 rtl/pipe_ctrl_unit.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Hazard and sequencing controller for the 5-stage pipeline: PC mux select,
// IF/ID and ID/EX control, load-use stalls, redirect squash, return-stack depth and halt drain.
module pipe_ctrl_unit #(
  parameter int REG_AW       = 3,
  parameter int STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int STACK_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              ex_ldm,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_br_taken,
  input  logic              ex_jmp,
  input  logic              ex_call,
  input  logic              ex_ret,
  output logic              pc_write,
  output logic [1:0]        pc_sel,
  output logic              if_id_wr,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              stack_push,
  output logic              stack_pop,
  output logic              halted,
  output logic              stack_err
);

  localparam int MAXC = (DRAIN_CYCLES > STALL_CYCLES) ? DRAIN_CYCLES : STALL_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
  localparam int DW   = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [DW-1:0]   depth_reg, depth_next;
  logic            err_reg, err_next;

  logic [1:0]        src_use;
  logic [1:0]        src_hit;
  logic [REG_AW-1:0] src_reg [2];
  logic              hazard;
  logic              redirect;
  logic              stack_fault;

  assign src_use    = {id_use2, id_use1};
  assign src_reg[0] = id_rs1;
  assign src_reg[1] = id_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] && (src_reg[gi] == ex_rd);
    end
  endgenerate

  assign hazard   = ex_ldm && (|src_hit);
  assign redirect = ex_ret || ex_call || ex_jmp || ex_br_taken;
  // Ret has priority, so a call only faults when no ret accompanies it.
  assign stack_fault = (ex_ret && (depth_reg == '0)) ||
                       (!ex_ret && ex_call && (depth_reg == DEPTH_MAX));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    depth_next  = depth_reg;
    err_next    = err_reg;
    pc_write    = 1'b0;
    pc_sel      = 2'd0;
    if_id_wr    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    halted      = 1'b0;
    stack_err   = err_reg;

    if (!rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      stack_err   = 1'b0;
    end else begin
      case (state_reg)
        RUN, DRAIN: begin
          if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (stack_fault) begin
              err_next   = 1'b1;
              state_next = HALTED;
            end else begin
              pc_write   = 1'b1;
              if_id_wr   = 1'b1;
              pc_sel     = ex_ret ? 2'd3 : ((ex_call || ex_jmp) ? 2'd2 : 2'd1);
              stack_push = !ex_ret && ex_call;
              stack_pop  = ex_ret;
              if (ex_ret)
                depth_next = depth_reg - DW'(1);
              else if (ex_call)
                depth_next = depth_reg + DW'(1);
              state_next = RUN;
            end
          end else if (state_reg == DRAIN) begin
            // Older instructions keep retiring while fetch is frozen.
            if_id_wr    = 1'b1;
            if_id_flush = 1'b1;
            if (cnt_reg <= CW'(1))
              state_next = HALTED;
            else
              cnt_next = cnt_reg - CW'(1);
          end else if (hazard) begin
            id_ex_flush = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_next = STALL;
              cnt_next   = CW'(STALL_CYCLES - 1);
            end
          end else if (halt) begin
            if_id_wr    = 1'b1;
            if_id_flush = 1'b1;
            state_next  = DRAIN;
            cnt_next    = CW'(DRAIN_CYCLES);
          end else begin
            pc_write = 1'b1;
            if_id_wr = 1'b1;
          end
        end
        STALL: begin
          id_ex_flush = 1'b1;
          if (cnt_reg <= CW'(1))
            state_next = RUN;
          else
            cnt_next = cnt_reg - CW'(1);
        end
        default: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          halted      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      depth_reg <= depth_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: inputs change on the falling edge and the
// Mealy outputs are compared 1 ns later against hand-computed output patterns.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       halt;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_use1, id_use2, ex_ldm;
  logic       ex_br_taken, ex_jmp, ex_call, ex_ret;
  logic       pc_write, if_id_wr, if_id_flush, id_ex_flush;
  logic [1:0] pc_sel;
  logic       stack_push, stack_pop, halted, stack_err;

  int total = 0;
  int bad   = 0;

  // {pc_write, pc_sel, if_id_wr, if_id_flush, id_ex_flush, push, pop, halted, err}
  logic [9:0] obs;
  assign obs = {pc_write, pc_sel, if_id_wr, if_id_flush, id_ex_flush,
                stack_push, stack_pop, halted, stack_err};

  localparam logic [9:0] E_RUN    = 10'b1_00_1_0_0_0_0_0_0;
  localparam logic [9:0] E_RST    = 10'b0_00_0_1_1_0_0_0_0;
  localparam logic [9:0] E_STALL  = 10'b0_00_0_0_1_0_0_0_0;
  localparam logic [9:0] E_JMP    = 10'b1_10_1_1_1_0_0_0_0;
  localparam logic [9:0] E_BR     = 10'b1_01_1_1_1_0_0_0_0;
  localparam logic [9:0] E_CALL   = 10'b1_10_1_1_1_1_0_0_0;
  localparam logic [9:0] E_RET    = 10'b1_11_1_1_1_0_1_0_0;
  localparam logic [9:0] E_DRAIN  = 10'b0_00_1_1_0_0_0_0_0;
  localparam logic [9:0] E_HALTED = 10'b0_00_0_1_1_0_0_1_0;
  localparam logic [9:0] E_HERR   = 10'b0_00_0_1_1_0_0_1_1;
  localparam logic [9:0] E_FAULT  = 10'b0_00_0_1_1_0_0_0_0;

  pipe_ctrl_unit #(
    .REG_AW(3), .STALL_CYCLES(2), .DRAIN_CYCLES(3), .STACK_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_ldm(ex_ldm), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken), .ex_jmp(ex_jmp),
    .ex_call(ex_call), .ex_ret(ex_ret),
    .pc_write(pc_write), .pc_sel(pc_sel), .if_id_wr(if_id_wr),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stack_push(stack_push), .stack_pop(stack_pop),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    halt = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use1 = 0; id_use2 = 0; ex_ldm = 0;
    ex_br_taken = 0; ex_jmp = 0; ex_call = 0; ex_ret = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); clear_inputs(); rst = 0;
    @(negedge clk); rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; clear_inputs();
    #1;
    total++;
    if (obs !== E_RST) begin bad++; $display("FAIL reset_hold: got %b want %b", obs, E_RST); end
    else $display("reset_hold obs=%b", obs);
    @(negedge clk); rst = 1; #1;
    total++;
    if (obs !== E_RUN) begin bad++; $display("FAIL reset_release: got %b want %b", obs, E_RUN); end
    else $display("reset_release obs=%b", obs);
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk); clear_inputs(); halt = 1;
    @(negedge clk); halt = 0;
    @(negedge clk); rst = 0; #1;  // second drain cycle, count 2, no edge yet
    total++;
    if (obs !== E_RST) begin bad++; $display("FAIL reset_mid_drain: got %b want %b", obs, E_RST); end
    else $display("reset_mid_drain obs=%b", obs);
    @(negedge clk); rst = 1; #1;
    total++;
    if (obs !== E_RUN) begin bad++; $display("FAIL reset_mid_drain_release: got %b want %b", obs, E_RUN); end
    else $display("reset_mid_drain_release obs=%b", obs);
    @(negedge clk); #1;
    total++;
    if (obs !== E_RUN) begin bad++; $display("FAIL reset_mid_drain_run: got %b want %b", obs, E_RUN); end
    else $display("reset_mid_drain_run obs=%b", obs);
  endtask

  task automatic test_load_use();
    logic [9:0] want [3];
    want[0] = E_STALL; want[1] = E_STALL; want[2] = E_RUN;
    for (int src = 0; src < 2; src++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); clear_inputs();
        if (c == 0) begin
          ex_ldm = 1; ex_rd = 3;
          if (src == 0) begin id_rs1 = 3; id_use1 = 1; end
          else begin id_rs2 = 3; id_use2 = 1; end
        end
        #1;
        total++;
        if (obs !== want[c]) begin bad++; $display("FAIL load_use src%0d c%0d: got %b want %b", src, c, obs, want[c]); end
        else $display("load_use src%0d c%0d obs=%b", src, c, obs);
      end
    end
    @(negedge clk); clear_inputs(); ex_ldm = 1; ex_rd = 3; id_rs1 = 3; id_use1 = 0; #1;
    total++;
    if (obs !== E_RUN) begin bad++; $display("FAIL load_use_nouse: got %b want %b", obs, E_RUN); end
    else $display("load_use_nouse obs=%b", obs);
    @(negedge clk); clear_inputs(); ex_ldm = 1; ex_rd = 3; id_rs1 = 2; id_use1 = 1; #1;
    total++;
    if (obs !== E_RUN) begin bad++; $display("FAIL load_use_diff_reg: got %b want %b", obs, E_RUN); end
    else $display("load_use_diff_reg obs=%b", obs);
  endtask

  task automatic test_redirect_priority();
    @(negedge clk); clear_inputs(); ex_br_taken = 1; ex_jmp = 1; #1;
    total++;
    if (obs !== E_JMP) begin bad++; $display("FAIL br_jmp: got %b want %b", obs, E_JMP); end
    else $display("br_jmp obs=%b", obs);
    @(negedge clk); clear_inputs(); #1;
    total++;
    if (obs !== E_RUN) begin bad++; $display("FAIL br_jmp_after: got %b want %b", obs, E_RUN); end
    else $display("br_jmp_after obs=%b", obs);
    @(negedge clk); ex_br_taken = 1; #1;
    total++;
    if (obs !== E_BR) begin bad++; $display("FAIL br_only: got %b want %b", obs, E_BR); end
    else $display("br_only obs=%b", obs);
    @(negedge clk); clear_inputs(); #1;
    total++;
    if (obs !== E_RUN) begin bad++; $display("FAIL br_only_after: got %b want %b", obs, E_RUN); end
    else $display("br_only_after obs=%b", obs);
  endtask

  task automatic test_hazard_vs_ret();
    pulse_reset();
    @(negedge clk); clear_inputs(); ex_call = 1; #1;
    total++;
    if (obs !== E_CALL) begin bad++; $display("FAIL hvr_call: got %b want %b", obs, E_CALL); end
    else $display("hvr_call obs=%b", obs);
    @(negedge clk); clear_inputs(); ex_ret = 1; ex_ldm = 1; ex_rd = 3; id_rs1 = 3; id_use1 = 1; #1;
    total++;
    if (obs !== E_RET) begin bad++; $display("FAIL hvr_ret: got %b want %b", obs, E_RET); end
    else $display("hvr_ret obs=%b", obs);
    @(negedge clk); clear_inputs(); #1;
    total++;
    if (obs !== E_RUN) begin bad++; $display("FAIL hvr_no_stall: got %b want %b", obs, E_RUN); end
    else $display("hvr_no_stall obs=%b", obs);
    // Depth must now be zero, so another ret underflows.
    @(negedge clk); ex_ret = 1; #1;
    total++;
    if (obs !== E_FAULT) begin bad++; $display("FAIL hvr_depth0_ret: got %b want %b", obs, E_FAULT); end
    else $display("hvr_depth0_ret obs=%b", obs);
    @(negedge clk); clear_inputs(); #1;
    total++;
    if (obs !== E_HERR) begin bad++; $display("FAIL hvr_halted: got %b want %b", obs, E_HERR); end
    else $display("hvr_halted obs=%b", obs);
    pulse_reset();
  endtask

  task automatic test_halt_drain();
    @(negedge clk); clear_inputs(); halt = 1; #1;
    total++;
    if (obs !== E_DRAIN) begin bad++; $display("FAIL halt_fetch: got %b want %b", obs, E_DRAIN); end
    else $display("halt_fetch obs=%b", obs);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); clear_inputs();
      if (c == 5) ex_jmp = 1;
      #1;
      total++;
      if (obs !== ((c < 3) ? E_DRAIN : E_HALTED)) begin
        bad++; $display("FAIL halt_seq c%0d: got %b want %b", c, obs, (c < 3) ? E_DRAIN : E_HALTED);
      end else $display("halt_seq c%0d obs=%b", c, obs);
    end
    pulse_reset();
    @(negedge clk); clear_inputs(); halt = 1; #1;
    total++;
    if (obs !== E_DRAIN) begin bad++; $display("FAIL cancel_fetch: got %b want %b", obs, E_DRAIN); end
    else $display("cancel_fetch obs=%b", obs);
    @(negedge clk); halt = 0; #1;
    total++;
    if (obs !== E_DRAIN) begin bad++; $display("FAIL cancel_drain1: got %b want %b", obs, E_DRAIN); end
    else $display("cancel_drain1 obs=%b", obs);
    @(negedge clk); ex_jmp = 1; #1;
    total++;
    if (obs !== E_JMP) begin bad++; $display("FAIL cancel_jmp: got %b want %b", obs, E_JMP); end
    else $display("cancel_jmp obs=%b", obs);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); clear_inputs(); #1;
      total++;
      if (obs !== E_RUN) begin bad++; $display("FAIL cancel_run c%0d: got %b want %b", c, obs, E_RUN); end
      else $display("cancel_run c%0d obs=%b", c, obs);
    end
  endtask

  task automatic test_stack();
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); clear_inputs(); ex_call = 1; #1;
      total++;
      if (obs !== E_CALL) begin bad++; $display("FAIL stack_call%0d: got %b want %b", c, obs, E_CALL); end
      else $display("stack_call%0d obs=%b", c, obs);
    end
    @(negedge clk); ex_call = 1; #1;
    total++;
    if (obs !== E_FAULT) begin bad++; $display("FAIL stack_overflow: got %b want %b", obs, E_FAULT); end
    else $display("stack_overflow obs=%b", obs);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); clear_inputs(); if (c == 1) ex_call = 1; #1;
      total++;
      if (obs !== E_HERR) begin bad++; $display("FAIL stack_overflow_halt%0d: got %b want %b", c, obs, E_HERR); end
      else $display("stack_overflow_halt%0d obs=%b", c, obs);
    end
    pulse_reset();
    #1;
    total++;
    if (obs !== E_RUN) begin bad++; $display("FAIL stack_err_cleared: got %b want %b", obs, E_RUN); end
    else $display("stack_err_cleared obs=%b", obs);
    @(negedge clk); clear_inputs(); ex_ret = 1; #1;
    total++;
    if (obs !== E_FAULT) begin bad++; $display("FAIL stack_underflow: got %b want %b", obs, E_FAULT); end
    else $display("stack_underflow obs=%b", obs);
    @(negedge clk); clear_inputs(); #1;
    total++;
    if (obs !== E_HERR) begin bad++; $display("FAIL stack_underflow_halt: got %b want %b", obs, E_HERR); end
    else $display("stack_underflow_halt obs=%b", obs);
  endtask

  initial begin
    test_reset();
    test_reset_mid_drain();
    test_load_use();
    test_redirect_priority();
    test_hazard_vs_ret();
    test_halt_drain();
    test_stack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
